exceptwb_arbiter: RTL and testbench

- Collects exception writebacks from all sources (integer EXU ports, memory units, dispatch-stage illegal/fault detection) and keeps only the oldest by ROB age.
- Presents that one exception to the ROB over a single registered valid/ready port.
- Sits inside the control block between the exception sources and the ROB exceptwb input, replacing the fixed-priority 2:1 mux.
- Cleared by squash.

---
 rtl/exceptwb_if.sv | 33 +++
 rtl/exceptwb_arbiter.sv | 106 ++++++++++
 tb/tb_exceptwb_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/exceptwb_if.sv
// Exception writeback bundle: requester fan-in, single ROB-facing valid/ready port, drop statistics.
// master = sources/ROB side, slave = arbiter.
interface exceptwb_if #(
    parameter int unsigned REQ_NUM  = 4,
    parameter int unsigned ROB_SIZE = 64,
    parameter int unsigned CAUSE_W  = 5,
    parameter int unsigned XLEN     = 64,
    parameter int unsigned CNT_W    = 16
);
    localparam int unsigned RW = $clog2(ROB_SIZE) + 1;

    logic                              flush;
    logic [REQ_NUM-1:0]                req_vld;
    logic [REQ_NUM-1:0][RW-1:0]        req_rob_idx;
    logic [REQ_NUM-1:0][CAUSE_W-1:0]   req_cause;
    logic [REQ_NUM-1:0][XLEN-1:0]      req_tval;
    logic                              exc_vld;
    logic [RW-1:0]                     exc_rob_idx;
    logic [CAUSE_W-1:0]                exc_cause;
    logic [XLEN-1:0]                   exc_tval;
    logic                              exc_rdy;
    logic [CNT_W-1:0]                  drop_cnt;

    modport master (
        output flush, req_vld, req_rob_idx, req_cause, req_tval, exc_rdy,
        input  exc_vld, exc_rob_idx, exc_cause, exc_tval, drop_cnt
    );

    modport slave (
        input  flush, req_vld, req_rob_idx, req_cause, req_tval, exc_rdy,
        output exc_vld, exc_rob_idx, exc_cause, exc_tval, drop_cnt
    );
endinterface

// File: rtl/exceptwb_arbiter.sv
// Keeps the oldest (by ROB age) pending exception across all sources and presents it to the ROB.
// Younger or losing requests are discarded and counted in a saturating drop counter.
module exceptwb_arbiter #(
    parameter int unsigned REQ_NUM  = 4,
    parameter int unsigned ROB_SIZE = 64,
    parameter int unsigned CAUSE_W  = 5,
    parameter int unsigned XLEN     = 64,
    parameter int unsigned CNT_W    = 16
) (
    input logic        clk,
    input logic        rst,
    exceptwb_if.slave  bus
);
    localparam int unsigned RW = $clog2(ROB_SIZE) + 1;
    localparam int unsigned IW = RW - 1;
    localparam int unsigned DW = $clog2(REQ_NUM + 1);
    localparam int unsigned SW = CNT_W + DW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic               hold_vld;
    logic [RW-1:0]      hold_rob;
    logic [CAUSE_W-1:0] hold_cause;
    logic [XLEN-1:0]    hold_tval;
    logic [CNT_W-1:0]   drop_cnt;

    logic               sel_any;
    logic [RW-1:0]      sel_rob;
    logic [CAUSE_W-1:0] sel_cause;
    logic [XLEN-1:0]    sel_tval;
    logic [DW-1:0]      n_vld;

    logic               nxt_vld;
    logic               load;
    logic [DW-1:0]      drops;
    logic [SW-1:0]      cnt_sum;
    logic [CNT_W-1:0]   cnt_nxt;

    // Wrap flag flips each ROB lap: with differing flags the larger idx is the older one.
    function automatic logic is_older(input logic [RW-1:0] a, input logic [RW-1:0] b);
        if (a[RW-1] == b[RW-1]) return a[IW-1:0] < b[IW-1:0];
        return a[IW-1:0] > b[IW-1:0];
    endfunction

    // Oldest valid requester; strict comparison keeps the lowest index on ties.
    always_comb begin
        sel_any   = 1'b0;
        sel_rob   = '0;
        sel_cause = '0;
        sel_tval  = '0;
        n_vld     = '0;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            if (bus.req_vld[i]) begin
                n_vld = n_vld + DW'(1);
                if (!sel_any || is_older(bus.req_rob_idx[i], sel_rob)) begin
                    sel_any   = 1'b1;
                    sel_rob   = bus.req_rob_idx[i];
                    sel_cause = bus.req_cause[i];
                    sel_tval  = bus.req_tval[i];
                end
            end
        end
    end

    // Hold update and drop accounting; a displaced hold entry offsets the accepted winner.
    always_comb begin
        nxt_vld = hold_vld;
        load    = 1'b0;
        drops   = '0;
        if (bus.flush) begin
            nxt_vld = 1'b0;
        end else if (!hold_vld || bus.exc_rdy) begin
            nxt_vld = sel_any;
            load    = sel_any;
            drops   = n_vld - DW'(load);
        end else begin
            load  = sel_any && is_older(sel_rob, hold_rob);
            drops = n_vld;
        end
        cnt_sum = SW'(drop_cnt) + SW'(drops);
        cnt_nxt = (cnt_sum > SW'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_vld   <= 1'b0;
            hold_rob   <= '0;
            hold_cause <= '0;
            hold_tval  <= '0;
            drop_cnt   <= '0;
        end else begin
            hold_vld <= nxt_vld;
            drop_cnt <= cnt_nxt;
            if (load) begin
                hold_rob   <= sel_rob;
                hold_cause <= sel_cause;
                hold_tval  <= sel_tval;
            end
        end
    end

    assign bus.exc_vld     = hold_vld;
    assign bus.exc_rob_idx = hold_rob;
    assign bus.exc_cause   = hold_cause;
    assign bus.exc_tval    = hold_tval;
    assign bus.drop_cnt    = drop_cnt;
endmodule

// File: tb/tb_exceptwb_arbiter.sv
// Bench for exceptwb_arbiter: directed vector table, async reset, then random traffic against an age-key model.
// A second instance with a 2-bit counter observes the same traffic to exercise saturation.
module tb_exceptwb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    exceptwb_if #(.CNT_W(16)) if_a ();
    exceptwb_if #(.CNT_W(2))  if_b ();

    assign if_b.flush       = if_a.flush;
    assign if_b.req_vld     = if_a.req_vld;
    assign if_b.req_rob_idx = if_a.req_rob_idx;
    assign if_b.req_cause   = if_a.req_cause;
    assign if_b.req_tval    = if_a.req_tval;
    assign if_b.exc_rdy     = if_a.exc_rdy;

    exceptwb_arbiter #(.CNT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(if_a.slave));
    exceptwb_arbiter #(.CNT_W(2))  u_sat (.clk(clk), .rst(rst), .bus(if_b.slave));

    typedef struct {
        logic             flush;
        logic [3:0]       vld;
        logic [3:0][6:0]  rob;
        logic             rdy;
        logic             ev;
        logic [6:0]       erob;
        int               esrc;
        int               edrop;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [63:0] tv(input logic [6:0] r, input int i);
        return {32'hC0DE0000 + 32'(i), 25'd0, r};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic fl, input logic [3:0] v, input logic [6:0] r0, input logic [6:0] r1,
                       input logic [6:0] r2, input logic [6:0] r3, input logic rdy, input logic ev,
                       input logic [6:0] erob, input int esrc, input int edrop);
        vec_t t;
        t.flush = fl; t.vld = v; t.rob = {r3, r2, r1, r0}; t.rdy = rdy;
        t.ev = ev; t.erob = erob; t.esrc = esrc; t.edrop = edrop;
        tbl.push_back(t);
    endtask

    task automatic drive(input logic fl, input logic [3:0] v, input logic [3:0][6:0] r, input logic rdy);
        if_a.flush   = fl;
        if_a.req_vld = v;
        if_a.exc_rdy = rdy;
        for (int i = 0; i < 4; i++) begin
            if_a.req_rob_idx[i] = r[i];
            if_a.req_cause[i]   = 5'(i + 2);
            if_a.req_tval[i]    = tv(r[i], i);
        end
    endtask

    task automatic check_out(input string nm, input logic ev, input logic [6:0] erob, input int esrc,
                             input int edrop);
        chk({nm, " vld"}, 64'(if_a.exc_vld), 64'(ev));
        if (ev) begin
            chk({nm, " rob"},   64'(if_a.exc_rob_idx), 64'(erob));
            chk({nm, " cause"}, 64'(if_a.exc_cause),   64'(5'(esrc + 2)));
            chk({nm, " tval"},  if_a.exc_tval,         tv(erob, esrc));
        end
        chk({nm, " drop"},     64'(if_a.drop_cnt), 64'(edrop));
        chk({nm, " drop_sat"}, 64'(if_b.drop_cnt), 64'((edrop > 3) ? 3 : edrop));
    endtask

    task automatic check_zero(input string nm);
        chk({nm, " vld"},   64'(if_a.exc_vld),     64'd0);
        chk({nm, " rob"},   64'(if_a.exc_rob_idx), 64'd0);
        chk({nm, " cause"}, 64'(if_a.exc_cause),   64'd0);
        chk({nm, " tval"},  if_a.exc_tval,         64'd0);
        chk({nm, " drop"},  64'(if_a.drop_cnt),    64'd0);
        chk({nm, " sat"},   64'(if_b.drop_cnt),    64'd0);
        chk({nm, " svld"},  64'(if_b.exc_vld),     64'd0);
    endtask

    // Age as distance from the current window base; smaller key = older.
    function automatic int key(input logic [6:0] r, input int base);
        return (int'(r) - base) & 127;
    endfunction

    initial begin
        logic [3:0][6:0] rr;
        logic [3:0]      v;
        logic            fl, rdy, m_vld;
        logic [6:0]      m_rob;
        int              m_src, total, base, nreq, win;

        drive(1'b0, 4'b0, '0, 1'b0);
        #2;
        check_zero("reset");
        #10 rst = 1'b1;

        //  fl  vld      r0     r1     r2     r3     rdy ev  erob   src drop
        add(0, 4'b0001, 7'h05, 7'h00, 7'h00, 7'h00, 0,  1, 7'h05, 0, 0);
        add(0, 4'b0000, 7'h00, 7'h00, 7'h00, 7'h00, 1,  0, 7'h00, 0, 0);
        add(0, 4'b1010, 7'h00, 7'h10, 7'h00, 7'h08, 0,  1, 7'h08, 3, 1);
        add(0, 4'b0000, 7'h00, 7'h00, 7'h00, 7'h00, 1,  0, 7'h00, 0, 1);
        add(0, 4'b0001, 7'h3C, 7'h00, 7'h00, 7'h00, 0,  1, 7'h3C, 0, 1);
        add(0, 4'b0100, 7'h00, 7'h00, 7'h42, 7'h00, 0,  1, 7'h3C, 0, 2);
        add(0, 4'b0001, 7'h3A, 7'h00, 7'h00, 7'h00, 0,  1, 7'h3A, 0, 3);
        add(0, 4'b0000, 7'h00, 7'h00, 7'h00, 7'h00, 1,  0, 7'h00, 0, 3);
        add(0, 4'b0010, 7'h00, 7'h20, 7'h00, 7'h00, 0,  1, 7'h20, 1, 3);
        for (int k = 0; k < 5; k++)
            add(0, 4'b0000, 7'h00, 7'h00, 7'h00, 7'h00, 0, 1, 7'h20, 1, 3);
        add(0, 4'b0010, 7'h00, 7'h30, 7'h00, 7'h00, 1,  1, 7'h30, 1, 3);
        add(0, 4'b0000, 7'h00, 7'h00, 7'h00, 7'h00, 1,  0, 7'h00, 0, 3);
        add(0, 4'b0001, 7'h11, 7'h00, 7'h00, 7'h00, 0,  1, 7'h11, 0, 3);
        add(1, 4'b0001, 7'h01, 7'h00, 7'h00, 7'h00, 0,  0, 7'h00, 0, 3);
        add(0, 4'b0000, 7'h00, 7'h00, 7'h00, 7'h00, 0,  0, 7'h00, 0, 3);
        add(0, 4'b1111, 7'h00, 7'h01, 7'h02, 7'h03, 0,  1, 7'h00, 0, 6);
        add(0, 4'b0110, 7'h00, 7'h00, 7'h00, 7'h00, 0,  1, 7'h00, 0, 8);
        add(0, 4'b0110, 7'h00, 7'h05, 7'h05, 7'h00, 1,  1, 7'h05, 1, 9);
        add(0, 4'b0000, 7'h00, 7'h00, 7'h00, 7'h00, 1,  0, 7'h00, 0, 9);

        @(posedge clk); #1;
        for (int n = 0; n < tbl.size(); n++) begin
            drive(tbl[n].flush, tbl[n].vld, tbl[n].rob, tbl[n].rdy);
            @(posedge clk); #1;
            check_out($sformatf("vec%0d", n), tbl[n].ev, tbl[n].erob, tbl[n].esrc, tbl[n].edrop);
        end

        // Async reset in the middle of a pending exception.
        rr = '0; rr[0] = 7'h15;
        drive(1'b0, 4'b0001, rr, 1'b0);
        @(posedge clk); #1;
        check_out("pre_rst", 1'b1, 7'h15, 0, 9);
        drive(1'b0, 4'b0000, '0, 1'b0);
        #3 rst = 1'b0;
        #1 check_zero("mid_rst");
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check_zero("post_rst");

        // Random traffic; all live robIdx lie within one 64-entry window starting at base.
        m_vld = 1'b0; m_rob = '0; m_src = 0; total = 0;
        base = $urandom_range(0, 127);
        for (int c = 0; c < 3000; c++) begin
            fl  = ($urandom_range(0, 39) == 0);
            v   = ($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom);
            rdy = 1'($urandom_range(0, 1));
            begin
                bit narrow = ($urandom_range(0, 3) == 0);
                for (int i = 0; i < 4; i++)
                    rr[i] = 7'((base + (narrow ? $urandom_range(0, 3) : $urandom_range(0, 63))) % 128);
            end
            nreq = 0; win = -1;
            for (int i = 0; i < 4; i++) begin
                if (v[i]) begin
                    nreq++;
                    if (win < 0 || key(rr[i], base) < key(rr[win], base)) win = i;
                end
            end
            if (fl) begin
                m_vld = 1'b0;
            end else begin
                total += nreq;
                if (!m_vld || rdy) begin
                    m_vld = (win >= 0);
                    if (win >= 0) begin m_rob = rr[win]; m_src = win; total -= 1; end
                end else if (win >= 0 && key(rr[win], base) < key(m_rob, base)) begin
                    // winner held, old hold discarded: net drop count unchanged
                    m_rob = rr[win]; m_src = win;
                end
            end
            drive(fl, v, rr, rdy);
            @(posedge clk); #1;
            check_out($sformatf("rnd%0d", c), m_vld, m_rob, m_src, total);
            if (fl) base = $urandom_range(0, 127);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
